rv32i_ifetch: RTL
=================

RV32I_IFETCH -- requirements
Module: rv32i_ifetch

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset, with bits [1:0] zero.
REQ-002 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_addr  output  32  word-aligned fetch address.
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_rsp_valid  input  1  read data valid; arrives at least 1 cycle after acceptance.
REQ-008 imem_rsp_data  input  32  instruction word.
REQ-009 redirect_valid  input  1  branch/jump redirect from the execute stage.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 out_valid  output  1  instruction available to the field decoder.
REQ-012 out_instr  output  32  instruction word feeding the field decoder.
REQ-013 out_pc  output  32  address of out_instr.
REQ-014 out_ready  input  1  downstream consumes the instruction this cycle.

Function
REQ-015 The block SHALL hold a fetch_pc register, a one-entry output buffer {out_instr, out_pc, out_valid}, and a 3-state FSM: IDLE, WAIT, WAIT_KILL.
REQ-016 imem_req_addr SHALL equal fetch_pc.
REQ-017 imem_req_valid SHALL be 1 only when all of the following hold: state is IDLE; out_valid is 0 or out_ready is 1; redirect_valid is 0.
REQ-018 Request acceptance (imem_req_valid and imem_req_ready) SHALL cause all of the following on the next edge: state goes to WAIT; the request address is latched as req_pc; fetch_pc becomes fetch_pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 When imem_req_valid is 1 and imem_req_ready is 0, the block SHALL keep imem_req_valid and imem_req_addr stable until acceptance or redirect.
REQ-020 In WAIT, with imem_rsp_valid and no redirect, the block SHALL do all of the following: load out_instr with imem_rsp_data; load out_pc with req_pc; set out_valid to 1; move to IDLE. Latency from acceptance to out_valid SHALL be the response latency plus 1 cycle.
REQ-021 The output buffer SHALL be empty whenever a response is loaded; the issue rule in REQ-017 guarantees this, and the bench SHALL assert it.
REQ-022 While out_valid is 1 and out_ready is 0, out_instr and out_pc SHALL hold stable; out_valid and out_ready together SHALL clear out_valid on the next edge.
REQ-023 A redirect SHALL have priority over every other event, and on the next edge it SHALL:
  - set fetch_pc to {redirect_pc[31:2], 2'b00};
  - clear out_valid, whatever the value of out_ready;
  - move WAIT to WAIT_KILL if no response arrives in the same cycle;
  - move WAIT to IDLE with the response discarded if a response arrives in the same cycle;
  - leave IDLE in IDLE and WAIT_KILL in WAIT_KILL.
REQ-024 In WAIT_KILL, an imem_rsp_valid SHALL be discarded (no buffer update) and the FSM SHALL move to IDLE.
REQ-025 imem_rsp_valid in IDLE SHALL be ignored.
REQ-026 The block SHALL have at most one outstanding memory request at any time.

Reset
REQ-027 While rst is 1, on each edge the block SHALL set: state to IDLE; fetch_pc to RESET_PC; out_valid to 0; out_instr to 32'h0; out_pc to 32'h0; req_pc to 32'h0. rst SHALL have priority over redirect and response.
REQ-028 A response to a request issued before reset SHALL be ignored per REQ-025.
REQ-029 imem_req_valid SHALL be 0 during reset and MAY assert in the first cycle after rst is 0.

Verification
REQ-030 Sequential fetch, memory with 1-cycle latency and always ready, out_ready=1 -> out_pc sequence 0x0, 0x4, 0x8, with one new instruction every 2 cycles and out_instr matching memory contents.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 -> out_instr and out_pc stable, imem_req_valid=0; on release, the next request address is out_pc+4.
REQ-032 Redirect to 0x0000_0102 while in WAIT -> the pending response is dropped, the next request address is 0x0000_0100, and no instruction from the old path reaches the output.
REQ-033 Redirect in the same cycle as imem_rsp_valid -> the response is discarded, state returns to IDLE, and the next request address is the redirect target.
REQ-034 Wrap-around: redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
REQ-035 rst pulsed while in WAIT with RESET_PC=0x8000_0000, and the old response arriving after reset -> response ignored, out_valid=0, and the first request address is 0x8000_0000.

Source files
------------

// File: rtl/rv32i_ifetch.sv
// RV32I instruction fetch: one outstanding imem request, one-entry output buffer,
// redirect squashes the in-flight response and the buffered instruction.
module rv32i_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WAIT_KILL
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        out_valid_q, out_valid_d;
    logic        req_fire;
    logic        rsp_load;
    logic        unused_redirect_lo;

    assign unused_redirect_lo = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A response arriving in WAIT_KILL always drains the kill, even under a
    // concurrent redirect, so the FSM can never wait for a response that already came.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            case (state_q)
                WAIT:      state_d = imem_rsp_valid ? IDLE : WAIT_KILL;
                WAIT_KILL: state_d = imem_rsp_valid ? IDLE : WAIT_KILL;
                default:   state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE:      if (req_fire) state_d = WAIT;
                WAIT:      if (imem_rsp_valid) state_d = IDLE;
                WAIT_KILL: if (imem_rsp_valid) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req_valid = !rst && (state_q == IDLE) && (!out_valid_q || out_ready)
                         && !redirect_valid;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_load       = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;
        if (redirect_valid) begin
            fetch_pc_d  = {redirect_pc[31:2], 2'b00};
            out_valid_d = 1'b0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                req_pc_d   = fetch_pc_q;
            end
            if (rsp_load) begin
                out_instr_d = imem_rsp_data;
                out_pc_d    = req_pc_q;
                out_valid_d = 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign imem_req_addr = fetch_pc_q;
    assign out_valid     = out_valid_q;
    assign out_instr     = out_instr_q;
    assign out_pc        = out_pc_q;

endmodule
